// File: rtl/cnn_fc_loader_pkg.sv
// Shared types and constants for the CNN/FC weight loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_CNN = 3'd1,
        ST_LOAD_IMG = 3'd2,
        ST_LOAD_FC  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int DEF_CNN_WORDS = 50704;
    localparam int DEF_IMG_WORDS = 1024;
    localparam int DEF_FC_WORDS  = 11218;

    localparam int CNN_ADDR_W = 16;
    localparam int FC_ADDR_W  = 14;

    // Counter width able to hold indices 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_fc_loader_if.sv
// Source word stream into the loader: valid/ready handshake plus data.
interface cnn_fc_loader_if #(
    parameter int DATA_W = 16
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, in_data, input in_ready);
    modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/cnn_fc_loader_phase_counter.sv
// Word index counter for one load phase; raises last on index BOUND-1.
module phase_counter
    import loader_pkg::*;
#(
    parameter int BOUND = 4,
    parameter int W     = cnt_width(BOUND)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last
);
    localparam logic [W-1:0] LAST_IDX = W'(BOUND - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins; after the final word the index returns to 0 so it never exceeds the bound.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST_IDX) ? '0 : count_q + 1'b1;
        end
    end

    // Index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_IDX);

endmodule

// File: rtl/cnn_fc_loader.sv
// CNN/FC loader: streams CNN weights, then image words (placed after the
// weights in CNN memory), then FC weights into their write ports.
// Optional running word checksum enabled by CNN_FC_LOADER_CHECKSUM_EN.
//
// state       | meaning
// ST_IDLE     | waiting for load
// ST_LOAD_CNN | accepting CNN weight words
// ST_LOAD_IMG | accepting image words
// ST_LOAD_FC  | accepting FC weight words
// ST_DONE     | all words written; load restarts
module cnn_fc_loader
    import loader_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CNN_WORDS = DEF_CNN_WORDS,
    parameter int IMG_WORDS = DEF_IMG_WORDS,
    parameter int FC_WORDS  = DEF_FC_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    cnn_fc_loader_if.slave        src,
    output logic                  cnn_we,
    output logic [CNN_ADDR_W-1:0] cnn_addr,
    output logic [DATA_W-1:0]     cnn_wdata,
    output logic                  fc_we,
    output logic [FC_ADDR_W-1:0]  fc_addr,
    output logic [DATA_W-1:0]     fc_wdata,
    output logic                  busy,
    output logic                  load_done,
    output logic [DATA_W-1:0]     checksum
);
    localparam int CNN_CW = cnt_width(CNN_WORDS);
    localparam int IMG_CW = cnt_width(IMG_WORDS);
    localparam int FC_CW  = cnt_width(FC_WORDS);

    state_t                state_q, state_d;
    logic                  cnn_we_q, cnn_we_d;
    logic [CNN_ADDR_W-1:0] cnn_addr_q, cnn_addr_d;
    logic [DATA_W-1:0]     cnn_wdata_q, cnn_wdata_d;
    logic                  fc_we_q, fc_we_d;
    logic [FC_ADDR_W-1:0]  fc_addr_q, fc_addr_d;
    logic [DATA_W-1:0]     fc_wdata_q, fc_wdata_d;

    logic              in_load;
    logic              xfer;
    logic              start;
    logic [CNN_CW-1:0] cnn_idx;
    logic [IMG_CW-1:0] img_idx;
    logic [FC_CW-1:0]  fc_idx;
    logic              cnn_last, img_last, fc_last;

    // Ready depends on state only so the source can never create a combinational loop.
    assign in_load      = (state_q == ST_LOAD_CNN) || (state_q == ST_LOAD_IMG) ||
                          (state_q == ST_LOAD_FC);
    assign src.in_ready = in_load;
    assign busy         = in_load;
    assign load_done    = (state_q == ST_DONE);
    assign xfer         = src.in_valid && in_load;
    assign start        = load && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    phase_counter #(.BOUND(CNN_WORDS)) u_cnt_cnn (
        .clk(clk), .rst(rst), .clr(start),
        .en(xfer && (state_q == ST_LOAD_CNN)),
        .count(cnn_idx), .last(cnn_last)
    );

    phase_counter #(.BOUND(IMG_WORDS)) u_cnt_img (
        .clk(clk), .rst(rst), .clr(start),
        .en(xfer && (state_q == ST_LOAD_IMG)),
        .count(img_idx), .last(img_last)
    );

    phase_counter #(.BOUND(FC_WORDS)) u_cnt_fc (
        .clk(clk), .rst(rst), .clr(start),
        .en(xfer && (state_q == ST_LOAD_FC)),
        .count(fc_idx), .last(fc_last)
    );

    // Next state and next write-port contents; addresses/data hold between writes.
    always_comb begin
        state_d     = state_q;
        cnn_we_d    = 1'b0;
        cnn_addr_d  = cnn_addr_q;
        cnn_wdata_d = cnn_wdata_q;
        fc_we_d     = 1'b0;
        fc_addr_d   = fc_addr_q;
        fc_wdata_d  = fc_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_LOAD_CNN;
            end
            ST_LOAD_CNN: begin
                if (xfer) begin
                    cnn_we_d    = 1'b1;
                    cnn_addr_d  = CNN_ADDR_W'(cnn_idx);
                    cnn_wdata_d = src.in_data;
                    if (cnn_last) state_d = ST_LOAD_IMG;
                end
            end
            ST_LOAD_IMG: begin
                if (xfer) begin
                    cnn_we_d    = 1'b1;
                    cnn_addr_d  = CNN_ADDR_W'(CNN_WORDS) + CNN_ADDR_W'(img_idx);
                    cnn_wdata_d = src.in_data;
                    if (img_last) state_d = ST_LOAD_FC;
                end
            end
            ST_LOAD_FC: begin
                if (xfer) begin
                    fc_we_d    = 1'b1;
                    fc_addr_d  = FC_ADDR_W'(fc_idx);
                    fc_wdata_d = src.in_data;
                    if (fc_last) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (load) state_d = ST_LOAD_CNN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered write ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnn_we_q    <= 1'b0;
            cnn_addr_q  <= '0;
            cnn_wdata_q <= '0;
            fc_we_q     <= 1'b0;
            fc_addr_q   <= '0;
            fc_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnn_we_q    <= cnn_we_d;
            cnn_addr_q  <= cnn_addr_d;
            cnn_wdata_q <= cnn_wdata_d;
            fc_we_q     <= fc_we_d;
            fc_addr_q   <= fc_addr_d;
            fc_wdata_q  <= fc_wdata_d;
        end
    end

    assign cnn_we    = cnn_we_q;
    assign cnn_addr  = cnn_addr_q;
    assign cnn_wdata = cnn_wdata_q;
    assign fc_we     = fc_we_q;
    assign fc_addr   = fc_addr_q;
    assign fc_wdata  = fc_wdata_q;

`ifdef CNN_FC_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;

    // Modulo word sum of accepted words, restarted with each load.
    always_comb begin
        sum_d = sum_q;
        if (start) begin
            sum_d = '0;
        end else if (xfer) begin
            sum_d = sum_q + src.in_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_cnn_fc_loader.sv
// Bench for cnn_fc_loader: a small-configuration instance and a default
// instance share one stimulus stream; each is checked every cycle against a
// word-count model (global word index k decides memory and address).
module tb_cnn_fc_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        drv_valid = 1'b0;
    logic [15:0] drv_data = '0;

    always #5 clk = ~clk;

    cnn_fc_loader_if #(.DATA_W(16)) if_s ();
    cnn_fc_loader_if #(.DATA_W(16)) if_d ();

    assign if_s.in_valid = drv_valid;
    assign if_s.in_data  = drv_data;
    assign if_d.in_valid = drv_valid;
    assign if_d.in_data  = drv_data;

    logic [1:0]       o_cnn_we, o_fc_we, o_busy, o_done, o_ready;
    logic [1:0][15:0] o_cnn_addr, o_cnn_wdata, o_fc_wdata, o_checksum;
    logic [1:0][13:0] o_fc_addr;

    assign o_ready[0] = if_s.in_ready;
    assign o_ready[1] = if_d.in_ready;

    cnn_fc_loader #(.DATA_W(16), .CNN_WORDS(4), .IMG_WORDS(2), .FC_WORDS(3)) dut_s (
        .clk(clk), .rst(rst), .load(load), .src(if_s),
        .cnn_we(o_cnn_we[0]), .cnn_addr(o_cnn_addr[0]), .cnn_wdata(o_cnn_wdata[0]),
        .fc_we(o_fc_we[0]), .fc_addr(o_fc_addr[0]), .fc_wdata(o_fc_wdata[0]),
        .busy(o_busy[0]), .load_done(o_done[0]), .checksum(o_checksum[0])
    );

    cnn_fc_loader dut_d (
        .clk(clk), .rst(rst), .load(load), .src(if_d),
        .cnn_we(o_cnn_we[1]), .cnn_addr(o_cnn_addr[1]), .cnn_wdata(o_cnn_wdata[1]),
        .fc_we(o_fc_we[1]), .fc_addr(o_fc_addr[1]), .fc_wdata(o_fc_wdata[1]),
        .busy(o_busy[1]), .load_done(o_done[1]), .checksum(o_checksum[1])
    );

    int          p_c[2], p_i[2], p_f[2];
    bit          m_started[2];
    int          m_k[2];
    logic [15:0] m_sum[2];
    bit          pw_v[2];
    int          pw_k[2];
    logic [15:0] pw_d[2];
    int          last_cnn_addr[2], last_fc_addr[2];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic bit m_loading(input int id);
        return m_started[id] && (m_k[id] < p_c[id] + p_i[id] + p_f[id]);
    endfunction

    function automatic bit m_done(input int id);
        return m_started[id] && (m_k[id] == p_c[id] + p_i[id] + p_f[id]);
    endfunction

    task automatic chk(input int id, input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] @%0t: got %0d expected %0d", tag, id, $time, obs, exp);
        end
    endtask

    task automatic post_check(input int id);
        int ci;
        bit ecw, efw;
        ci  = p_c[id] + p_i[id];
        ecw = pw_v[id] && (pw_k[id] < ci);
        efw = pw_v[id] && (pw_k[id] >= ci);
        chk(id, "cnn_we", 32'(o_cnn_we[id]), 32'(ecw));
        chk(id, "fc_we", 32'(o_fc_we[id]), 32'(efw));
        chk(id, "we_excl", 32'(o_cnn_we[id] & o_fc_we[id]), 32'd0);
        if (ecw) begin
            chk(id, "cnn_addr", 32'(o_cnn_addr[id]), 32'(pw_k[id]));
            chk(id, "cnn_wdata", 32'(o_cnn_wdata[id]), 32'(pw_d[id]));
        end
        if (efw) begin
            chk(id, "fc_addr", 32'(o_fc_addr[id]), 32'(pw_k[id] - ci));
            chk(id, "fc_wdata", 32'(o_fc_wdata[id]), 32'(pw_d[id]));
        end
        if (o_cnn_we[id]) last_cnn_addr[id] = int'(o_cnn_addr[id]);
        if (o_fc_we[id]) last_fc_addr[id] = int'(o_fc_addr[id]);
        chk(id, "busy", 32'(o_busy[id]), 32'(m_loading(id)));
        chk(id, "load_done", 32'(o_done[id]), 32'(m_done(id)));
`ifdef CNN_FC_LOADER_CHECKSUM_EN
        chk(id, "checksum", 32'(o_checksum[id]), 32'(m_sum[id]));
`else
        chk(id, "checksum", 32'(o_checksum[id]), 32'd0);
`endif
    endtask

    // One clock: drive at negedge, update model, check #1 after the rising edge.
    task automatic cycle(input logic v, input logic ld, input logic [15:0] d);
        drv_valid = v;
        load      = ld;
        drv_data  = d;
        #1;
        for (int id = 0; id < 2; id++) begin
            chk(id, "in_ready", 32'(o_ready[id]), 32'(m_loading(id)));
            pw_v[id] = 1'b0;
            if (v && m_loading(id)) begin
                pw_v[id]  = 1'b1;
                pw_k[id]  = m_k[id];
                pw_d[id]  = d;
                m_k[id]   = m_k[id] + 1;
                m_sum[id] = m_sum[id] + d;
            end else if (ld && !m_loading(id)) begin
                m_started[id] = 1'b1;
                m_k[id]       = 0;
                m_sum[id]     = '0;
            end
        end
        @(posedge clk);
        #1;
        for (int id = 0; id < 2; id++) post_check(id);
        @(negedge clk);
    endtask

    // Assert reset at a negedge; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int id = 0; id < 2; id++) begin
            chk(id, "rst_cnn_we", 32'(o_cnn_we[id]), 32'd0);
            chk(id, "rst_fc_we", 32'(o_fc_we[id]), 32'd0);
            chk(id, "rst_cnn_addr", 32'(o_cnn_addr[id]), 32'd0);
            chk(id, "rst_fc_addr", 32'(o_fc_addr[id]), 32'd0);
            chk(id, "rst_cnn_wdata", 32'(o_cnn_wdata[id]), 32'd0);
            chk(id, "rst_fc_wdata", 32'(o_fc_wdata[id]), 32'd0);
            chk(id, "rst_checksum", 32'(o_checksum[id]), 32'd0);
            chk(id, "rst_busy", 32'(o_busy[id]), 32'd0);
            chk(id, "rst_done", 32'(o_done[id]), 32'd0);
            chk(id, "rst_ready", 32'(o_ready[id]), 32'd0);
            m_started[id] = 1'b0;
            m_k[id]       = 0;
            m_sum[id]     = '0;
            pw_v[id]      = 1'b0;
        end
        drv_valid = 1'b0;
        load      = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        p_c[0] = 4;     p_i[0] = 2;    p_f[0] = 3;
        p_c[1] = 50704; p_i[1] = 1024; p_f[1] = 11218;
        for (int id = 0; id < 2; id++) begin
            m_started[id] = 1'b0; m_k[id] = 0; m_sum[id] = '0;
            pw_v[id] = 1'b0; pw_k[id] = 0; pw_d[id] = '0;
            last_cnn_addr[id] = -1; last_fc_addr[id] = -1;
        end

        @(negedge clk);
        do_reset();

        // Valid while idle transfers nothing.
        repeat (3) cycle(1'b1, 1'b0, 16'($urandom));

        // Continuous stream 1..9.
        cycle(1'b0, 1'b1, 16'd0);
        for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, 16'(i));
        repeat (2) cycle(1'b0, 1'b0, 16'd0);
`ifdef CNN_FC_LOADER_CHECKSUM_EN
        chk(0, "sum_1to9", 32'(o_checksum[0]), 32'd45);
`else
        chk(0, "sum_off", 32'(o_checksum[0]), 32'd0);
`endif
        chk(0, "done_after_9", 32'(o_done[0]), 32'd1);

        // Reload from DONE with valid toggling every other cycle.
        cycle(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 18; i++) cycle(logic'(i % 2 == 0), 1'b0, 16'(i / 2 + 1));
        cycle(1'b0, 1'b0, 16'd0);

        // Load pulse while the small instance is in its image phase.
        cycle(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 9; i++) cycle(1'b1, logic'(i == 5), 16'($urandom));
        chk(0, "done_after_ignored_load", 32'(o_done[0]), 32'd1);

        // Random valid and load pulses.
        for (int i = 0; i < 80; i++)
            cycle(logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 9) == 0),
                  16'($urandom));

        // Reset right after the third CNN transfer, then restart.
        do_reset();
        cycle(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'($urandom));
        chk(0, "pre_rst_cnn_we", 32'(o_cnn_we[0]), 32'd1);
        do_reset();
        cycle(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 16'($urandom));

        // Full default-size stream.
        do_reset();
        cycle(1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 62946 + 4; i++) cycle(1'b1, 1'b0, 16'($urandom));
        chk(1, "last_cnn_addr", 32'(last_cnn_addr[1]), 32'd51727);
        chk(1, "last_fc_addr", 32'(last_fc_addr[1]), 32'd11217);
        chk(1, "done_full", 32'(o_done[1]), 32'd1);
`ifdef CNN_FC_LOADER_CHECKSUM_EN
        chk(1, "sum_full", 32'(o_checksum[1]), 32'(m_sum[1]));
`else
        chk(1, "sum_full_off", 32'(o_checksum[1]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
